imm_packer: RTL and testbench

Immediate packer for the pipelined RISC-V datapath: the inverse of the immediate extractor. It accepts an instruction template plus a 64-bit immediate, inserts the immediate into the bit positions dictated by the format selector `template[6:5]`, and delivers the finished 32-bit instruction word through a 2-entry output FIFO with valid/ready handshakes. It feeds the instruction memory loader and the self-test instruction generator.

---
 rtl/imm_packer.sv | 107 ++++++++++
 tb/tb_imm_packer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/imm_packer.sv
// RISC-V immediate packer: inserts a 64-bit immediate into an instruction template and
// queues the result in a 2-entry FIFO. Optional range flag: IMM_PACKER_RANGE_CHECK_EN.
module imm_packer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_template,
  input  logic [63:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] pack_count
);

  // Format is chosen by template[6:5]; encodings 10 and 11 share the B-like layout.
  function automatic logic [31:0] pack_instr(input logic [31:0] tmpl,
                                             input logic signed [63:0] imm);
    logic [31:0] r;
    r = tmpl;
    case (tmpl[6:5])
      2'b00: r[31:20] = imm[11:0];
      2'b01: begin
        r[31:25] = imm[11:5];
        r[11:7]  = imm[4:0];
      end
      default: begin
        r[31]    = imm[11];
        r[7]     = imm[10];
        r[30:25] = imm[9:4];
        r[11:8]  = imm[3:0];
      end
    endcase
    return r;
  endfunction

  logic [31:0]      r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_occ;
  logic [CNT_W-1:0] r_cnt;

  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_packed;

  assign in_ready   = (r_occ != 2'd2);
  assign out_valid  = (r_occ != 2'd0);
  assign w_push     = in_valid && in_ready;
  assign w_pop      = out_valid && out_ready;
  assign w_packed   = pack_instr(in_template, in_imm);
  assign out_instr  = r_mem[r_rptr];
  assign pack_count = r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_occ    <= 2'd0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_packed;
        r_wptr        <= ~r_wptr;
        r_cnt         <= r_cnt + CNT_W'(1);
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

`ifdef IMM_PACKER_RANGE_CHECK_EN
  // Out of range when the upper 53 bits are not a pure sign extension of bit 11.
  function automatic logic range_err(input logic [63:0] imm);
    return !((&imm[63:11]) || (~|imm[63:11]));
  endfunction

  logic r_err [2];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err[0] <= 1'b0;
      r_err[1] <= 1'b0;
    end else if (w_push) begin
      r_err[r_wptr] <= range_err(in_imm);
    end
  end

  assign out_err = r_err[r_rptr];
`else
  logic w_unused_imm_hi;
  assign w_unused_imm_hi = ^in_imm[63:12];
  assign out_err         = 1'b0;
`endif

endmodule

// File: tb/tb_imm_packer.sv
// Randomized bench for imm_packer against a queue-based model of the FIFO and the
// immediate placement rules; the field layout is re-derived with masks and shifts.
module tb_imm_packer;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_template;
  logic [63:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] pack_count;

  imm_packer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_template(in_template), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .pack_count(pack_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [63:0] imm;
  } ent_t;

  ent_t             q[$];
  logic [CNT_W-1:0] m_cnt;
  int               n_tests = 0;
  int               n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit fits12(input logic [63:0] imm);
    return ($signed(imm) >= -64'sd2048) && ($signed(imm) <= 64'sd2047);
  endfunction

  function automatic logic [31:0] ref_pack(input logic [31:0] t, input logic [63:0] imm);
    logic [31:0] i12;
    i12 = {20'b0, imm[11:0]};
    if (t[6:5] == 2'b00)
      return (t & 32'h000F_FFFF) | (i12 << 20);
    else if (t[6:5] == 2'b01)
      return (t & 32'h01FF_F07F) | ((i12 >> 5) << 25) | ((i12 & 32'h1F) << 7);
    else
      return (t & 32'h01FF_F07F) | (((i12 >> 11) & 32'h1) << 31) |
             (((i12 >> 10) & 32'h1) << 7) | (((i12 >> 4) & 32'h3F) << 25) |
             ((i12 & 32'hF) << 8);
  endfunction

  // Immediate extractor: the inverse mapping, used for the round-trip property.
  function automatic logic [63:0] ref_extract(input logic [31:0] ins);
    int v;
    logic signed [63:0] r;
    if (ins[6:5] == 2'b00)      v = int'(ins[31:20]);
    else if (ins[6:5] == 2'b01) v = int'(ins[31:25]) * 32 + int'(ins[11:7]);
    else v = int'(ins[31]) * 2048 + int'(ins[7]) * 1024 + int'(ins[30:25]) * 16 + int'(ins[11:8]);
    if (v >= 2048) v = v - 4096;
    r = v;
    return r;
  endfunction

  function automatic logic ref_err(input logic [63:0] imm);
`ifdef IMM_PACKER_RANGE_CHECK_EN
    return !fits12(imm);
`else
    return 1'b0;
`endif
  endfunction

  task automatic cycle(input logic v, input logic [31:0] t, input logic [63:0] imm,
                       input logic rdy);
    ent_t e;
    bit   do_pop;
    bit   do_push;
    in_valid    = v;
    in_template = t;
    in_imm      = imm;
    out_ready   = rdy;
    check("in_ready", in_ready, q.size() != 2);
    check("out_valid", out_valid, q.size() != 0);
    check("pack_count", pack_count, m_cnt);
    if (q.size() > 0) begin
      check("out_instr", out_instr, q[0].instr);
      check("out_err", out_err, q[0].err);
      if (fits12(q[0].imm)) check("roundtrip", ref_extract(out_instr), q[0].imm);
    end
    if (reset) begin
      q.delete();
      m_cnt = '0;
    end else begin
      do_pop  = rdy && (q.size() > 0);
      do_push = v && (q.size() < 2);
      if (do_pop) e = q.pop_front();
      if (do_push) begin
        e.instr = ref_pack(t, imm);
        e.err   = ref_err(imm);
        e.imm   = imm;
        q.push_back(e);
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand_imm();
    int k;
    logic [63:0] r;
    k = $urandom_range(0, 3);
    case (k)
      0: r = {{52{1'b0}}, 12'($urandom)};
      1: r = 64'($signed(32'($urandom_range(0, 4095)) - 32'sd2048));
      2: r = {$urandom, $urandom};
      default: r = ($urandom_range(0, 1) == 1) ? 64'h0000_0000_0000_0800
                                               : 64'hFFFF_FFFF_FFFF_F7FF;
    endcase
    return r;
  endfunction

  logic [CNT_W-1:0] c0;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_template = '0; in_imm = '0;
    q.delete(); m_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_err", out_err, 1'b0);
    check("rst_count", pack_count, '0);

    // I-type, -1
    cycle(1'b1, 32'h0000_0013, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    check("i_instr", out_instr, 32'hFFF0_0013);
    check("i_count", pack_count, 16'd1);
    cycle(1'b0, 32'h0, 64'h0, 1'b1);

    // S-type round trip
    cycle(1'b1, 32'h0000_3023, 64'h7E5, 1'b1);
    check("s_hi", out_instr[31:25], 7'h3F);
    check("s_lo", out_instr[11:7], 5'h05);
    check("s_rt", ref_extract(out_instr), 64'h7E5);
    cycle(1'b0, 32'h0, 64'h0, 1'b1);

    // B-like, -2048
    cycle(1'b1, 32'h0000_0063, 64'hFFFF_FFFF_FFFF_F800, 1'b1);
    check("b_instr", out_instr, 32'h8000_0063);
    check("b_rt", ref_extract(out_instr), 64'hFFFF_FFFF_FFFF_F800);
    cycle(1'b0, 32'h0, 64'h0, 1'b1);

    // Backpressure: third pair waits until space frees up
    cycle(1'b1, 32'h0000_0013, 64'h111, 1'b0);
    cycle(1'b1, 32'h0000_0023, 64'h222, 1'b0);
    check("bp_full", in_ready, 1'b0);
    cycle(1'b1, 32'h0000_0063, 64'h333, 1'b0);
    cycle(1'b1, 32'h0000_0063, 64'h333, 1'b1);
    cycle(1'b1, 32'h0000_0063, 64'h333, 1'b1);
    cycle(1'b0, 32'h0, 64'h0, 1'b1);
    check("bp_drained", out_valid, 1'b0);

    // Steady push/pop at occupancy 1
    cycle(1'b1, 32'h0000_0013, 64'h5, 1'b1);
    c0 = pack_count;
    for (int i = 0; i < 20; i++) cycle(1'b1, $urandom, rand_imm(), 1'b1);
    check("pp_count", pack_count, c0 + 16'd20);
    check("pp_valid", out_valid, 1'b1);

    // Reset mid-stream
    reset = 1'b1;
    cycle(1'b1, 32'h0000_0013, 64'h7, 1'b1);
    reset = 1'b0;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_count", pack_count, '0);

    // Out-of-range immediate, I-type
    cycle(1'b1, 32'h0000_0013, 64'h800, 1'b0);
    check("rng_field", out_instr[31:20], 12'h800);
    check("rng_err", out_err, ref_err(64'h800));
    cycle(1'b0, 32'h0, 64'h0, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      cycle(($urandom_range(0, 3) != 0), $urandom, rand_imm(), ($urandom_range(0, 2) != 0));
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 64'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
